sram_controller: RTL and testbench
==================================

# sram_controller

- Sequences the CPU data-memory port onto an external 16-bit asynchronous SRAM.
- Sits between the MEM stage (EXE_Stage_Reg outputs) and the board SRAM, replacing the single-cycle Memory model.
- Splits each 32-bit access into two 16-bit halfword phases with programmable wait states.
- Drives `ready`; the top level ORs `~ready` into the pipeline freeze so the MEM stage stalls until the access completes.

## Interface

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- PHASE_CYCLES, 3: cycles per halfword phase, minimum 1.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- mem_r_en, input, 1: read request from the MEM stage.
- mem_w_en, input, 1: write request from the MEM stage.
- address, input, 32: byte address (alu_res), word aligned.
- data, input, 32: write data (val_rm).
- mem_result, output, 32: read data.
- ready, output, 1: high when the MEM stage may advance.
- sram_addr, output, 18: halfword address.
- sram_dq_out, output, 16: write data to the SRAM.
- sram_dq_in, input, 16: read data from the SRAM.
- sram_dq_oe, output, 1: data bus drive enable.
- sram_we_n, output, 1: active-low write strobe.

## Operation

- Word index: `w = (address - BASE_ADDR) >> 2`, using 17 bits. Low half is `sram_addr = {w, 1'b0}`; high half is `{w, 1'b1}`.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - `ready = ~(mem_r_en | mem_w_en)`, combinational.
  - A request captures the address, write data and kind, then moves to LO.
  - If both enables are high, the access is a write.
- LO, then HI: each phase lasts PHASE_CYCLES cycles, counted by a phase counter that wraps to 0 at the end of each phase. `ready = 0` in both states.
- Read phase:
  - `sram_dq_oe = 0`, `sram_we_n = 1`.
  - `sram_dq_in` is sampled on the last cycle of the phase, into bits [15:0] for LO and bits [31:16] for HI.
- Write phase:
  - `sram_dq_oe = 1` for the whole phase.
  - `sram_dq_out` carries data[15:0] in LO and data[31:16] in HI.
  - `sram_we_n = 0` on every cycle of the phase except the last. When PHASE_CYCLES = 1, it is low for that single cycle.
- DONE: one cycle with `ready = 1`.
  - On a read, `mem_result` is updated with the assembled word on entry to DONE.
  - DONE always returns to IDLE. A new request is not accepted in DONE.
- `mem_result` holds its last value until the next read completes. Writes do not change it, unless the read-hit feature is enabled (see Configuration).
- The requester holds `address`, `data` and the enables stable while `ready = 0`; the controller uses its captured copies.

## Timing

- Reset values: state IDLE, counter 0, `mem_result` 0, `sram_addr` 0, `sram_dq_out` 0, `sram_dq_oe` 0, `sram_we_n` 1. `ready` follows the IDLE rule.
- Every SRAM-side output is registered.
- With P = PHASE_CYCLES, a request first seen in cycle 0:
  - LO occupies cycles 1..P.
  - HI occupies cycles P+1..2P.
  - DONE is cycle 2P+1, with `ready = 1`.
  - `ready` is low in cycles 0..2P. The default freeze is 7 cycles.
- Back-to-back requests: the second request is seen in the cycle after DONE, giving 2P+2 cycles per access.
- Reset asserted mid-access: the controller returns immediately to reset values. A partial write may leave the SRAM inconsistent; no completion is signalled.

## Configuration

- `SRAM_CTRL_READ_HIT_EN` defined:
  - Adds a valid bit and a 17-bit tag for the word currently held in `mem_result`.
  - A read in IDLE whose w matches a valid tag is a hit: `ready = 1` that cycle, no SRAM access, state stays IDLE.
  - A completed read loads the tag and sets valid.
  - A write whose w matches the tag updates `mem_result` with data at DONE (write-through).
  - Reset clears valid.
- Undefined: every read goes to the SRAM, with no tag logic.

## Test plan

- Reset: assert rst mid-HI of a write -> next cycle `sram_we_n = 1`, `sram_dq_oe = 0`, state IDLE, `mem_result = 0`.
- Write: address 1024+8, data 0xDEADBEEF, P = 3 ->
  - LO: `sram_addr = 4`, `sram_dq_out = 0xBEEF`, `sram_we_n` low for 2 of 3 cycles.
  - HI: `sram_addr = 5`, `sram_dq_out = 0xDEAD`.
  - `ready` low for 7 cycles, then high for 1.
- Read: model returns 0x5678 at halfword 4 and 0x1234 at halfword 5; read address 1032 -> `mem_result = 0x12345678` in DONE (cycle 7).
- Simultaneous `mem_r_en = mem_w_en = 1` -> a write is performed and `mem_result` is unchanged.
- P = 1 back-to-back reads -> each `ready` pulse is 3 cycles after its request; 4 cycles per access.
- With `SRAM_CTRL_READ_HIT_EN`:
  - Repeat read of 1032 -> `ready = 1` in the same cycle, no `sram_addr` change.
  - Write 0xCAFEF00D to 1032, then read -> hit returns 0xCAFEF00D.

Source files
------------

// File: rtl/sram_controller.sv
// sram_controller: sequences 32-bit CPU data accesses onto a 16-bit async SRAM in two halfword phases.
// Define SRAM_CTRL_READ_HIT_EN to serve repeat reads of the word held in mem_result without an SRAM access.
module sram_controller #(
  parameter int BASE_ADDR = 1024,
  parameter int PHASE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] data,
  output logic [31:0] mem_result,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);
  localparam int CW = PHASE_CYCLES > 1 ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);
  localparam logic [1:0] IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [16:0] w_q, w_d, w_in;
  logic [31:0] wdat_q, wdat_d, mem_result_q, mem_result_d;
  logic wr_q, wr_d;
  logic [15:0] lo_q, lo_d, dq_out_q, dq_out_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic dq_oe_q, dq_oe_d, we_n_q, we_n_d;
  logic req, hit, take, phase_end, done_in, ph_d, hi_d;
`ifdef SRAM_CTRL_READ_HIT_EN
  logic [16:0] tag_q, tag_d;
  logic valid_q, valid_d;
`endif
  assign w_in = 17'((address - 32'(BASE_ADDR)) >> 2);
  always_comb begin
    req = mem_r_en | mem_w_en;
`ifdef SRAM_CTRL_READ_HIT_EN
    hit = mem_r_en & ~mem_w_en & valid_q & (w_in == tag_q);
`else
    hit = 1'b0;
`endif
    phase_end = cnt_q == LAST;
    take = state_q == IDLE && req && !hit;
    done_in = state_q == HI && phase_end;
    // LO -> HI -> DONE are consecutive encodings
    state_d = state_q == IDLE ? (take ? LO : IDLE)
            : state_q == DONE ? IDLE
            : phase_end ? state_q + 2'd1 : state_q;
    cnt_d = (state_q == LO || state_q == HI) && !phase_end ? cnt_q + 1'b1 : '0;
    w_d = take ? w_in : w_q;
    wdat_d = take ? data : wdat_q;
    wr_d = take ? mem_w_en : wr_q;
    lo_d = state_q == LO && phase_end ? sram_dq_in : lo_q;
`ifdef SRAM_CTRL_READ_HIT_EN
    mem_result_d = done_in && !wr_q ? {sram_dq_in, lo_q}
                 : done_in && valid_q && w_q == tag_q ? wdat_q : mem_result_q;
    tag_d = done_in && !wr_q ? w_q : tag_q;
    valid_d = valid_q | (done_in & ~wr_q);
`else
    mem_result_d = done_in && !wr_q ? {sram_dq_in, lo_q} : mem_result_q;
`endif
    // SRAM pins are registered, so they are computed from the next state
    ph_d = state_d == LO || state_d == HI;
    hi_d = state_d == HI;
    sram_addr_d = ph_d ? {w_d, hi_d} : sram_addr_q;
    dq_out_d = ph_d ? (hi_d ? wdat_d[31:16] : wdat_d[15:0]) : dq_out_q;
    dq_oe_d = ph_d & wr_d;
    we_n_d = ~(ph_d & wr_d & (cnt_d != LAST || PHASE_CYCLES == 1));
    ready = state_q == IDLE ? ~req | hit : state_q == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      w_q <= '0;
      wdat_q <= '0;
      wr_q <= 1'b0;
      lo_q <= '0;
      mem_result_q <= '0;
      sram_addr_q <= '0;
      dq_out_q <= '0;
      dq_oe_q <= 1'b0;
      we_n_q <= 1'b1;
`ifdef SRAM_CTRL_READ_HIT_EN
      tag_q <= '0;
      valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      w_q <= w_d;
      wdat_q <= wdat_d;
      wr_q <= wr_d;
      lo_q <= lo_d;
      mem_result_q <= mem_result_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q <= dq_out_d;
      dq_oe_q <= dq_oe_d;
      we_n_q <= we_n_d;
`ifdef SRAM_CTRL_READ_HIT_EN
      tag_q <= tag_d;
      valid_q <= valid_d;
`endif
    end
  end
  assign mem_result = mem_result_q;
  assign sram_addr = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_we_n = we_n_q;
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: transaction-level model plus directed checks for sram_controller (P=3 and P=1 instances).
module tb_sram_controller;
  localparam int P = 3;
  localparam int DK = 2 * P + 1;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic r_en = 0, w_en = 0;
  logic [31:0] addr = 0, wdata = 0, mem_result;
  logic ready, dq_oe, we_n;
  logic [17:0] sram_addr;
  logic [15:0] dq_out, dq_in;
  logic r1 = 0, w1 = 0;
  logic [31:0] a1 = 0, d1 = 0, mem_result1;
  logic ready1, dq_oe1, we_n1;
  logic [17:0] sram_addr1;
  logic [15:0] dq_out1, dq_in1 = 16'h00A5;
  int n_chk = 0, n_fail = 0;
  logic chk_en = 0;
  sram_controller dut (
    .clk(clk), .rst(rst), .mem_r_en(r_en), .mem_w_en(w_en), .address(addr), .data(wdata),
    .mem_result(mem_result), .ready(ready), .sram_addr(sram_addr), .sram_dq_out(dq_out),
    .sram_dq_in(dq_in), .sram_dq_oe(dq_oe), .sram_we_n(we_n));
  sram_controller #(.PHASE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .mem_r_en(r1), .mem_w_en(w1), .address(a1), .data(d1),
    .mem_result(mem_result1), .ready(ready1), .sram_addr(sram_addr1), .sram_dq_out(dq_out1),
    .sram_dq_in(dq_in1), .sram_dq_oe(dq_oe1), .sram_we_n(we_n1));
  // external SRAM device
  logic [15:0] sram_mem [0:63];
  logic ld_en = 0;
  logic [4:0] ld_w = 0;
  logic [31:0] ld_d = 0;
  assign dq_in = sram_mem[sram_addr[5:0]];
  always @(posedge clk)
    if (ld_en) begin
      sram_mem[{ld_w, 1'b0}] <= ld_d[15:0];
      sram_mem[{ld_w, 1'b1}] <= ld_d[31:16];
    end else if (!we_n && dq_oe) sram_mem[sram_addr[5:0]] <= dq_out;
  // model: k = cycles since the request was accepted (0 = idle)
  int k;
  logic [16:0] cw, tag, wreq;
  logic [31:0] cd, mres;
  logic cwr, valid, hit_m;
  logic [31:0] gold [0:31];
  assign wreq = 17'((addr - 32'd1024) >> 2);
`ifdef SRAM_CTRL_READ_HIT_EN
  assign hit_m = r_en & ~w_en & valid & (wreq == tag);
`else
  assign hit_m = 1'b0;
`endif
  always @(posedge clk or posedge rst)
    if (rst) begin
      k <= 0;
      mres <= 0;
      valid <= 0;
    end else begin
      if (ld_en) gold[ld_w] <= ld_d;
      if (k == 0) begin
        if ((r_en || w_en) && !hit_m) begin
          k <= 1; cw <= wreq; cd <= wdata; cwr <= w_en;
        end
      end else if (k == DK) k <= 0;
      else begin
        k <= k + 1;
        if (k == 2 * P) begin
          if (cwr) begin
            gold[cw[4:0]] <= cd;
`ifdef SRAM_CTRL_READ_HIT_EN
            if (valid && tag == cw) mres <= cd;
`endif
          end else begin
            mres <= gold[cw[4:0]]; tag <= cw; valid <= 1;
          end
        end
      end
    end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  logic m_hi, m_ph;
  int m_pos;
  always @(negedge clk)
    if (chk_en) begin
      m_hi = k > P;
      m_ph = k >= 1 && k <= 2 * P;
      m_pos = m_hi ? k - P - 1 : k - 1;
      check("ready", 32'(ready), k == 0 ? 32'(!(r_en || w_en) || hit_m) : 32'(k == DK));
      check("mem_result", mem_result, mres);
      check("sram_dq_oe", 32'(dq_oe), 32'(m_ph && cwr));
      check("sram_we_n", 32'(we_n), 32'(!(m_ph && cwr && (m_pos < P - 1 || P == 1))));
      if (m_ph) begin
        check("sram_addr", 32'(sram_addr), 32'({cw, m_hi}));
        if (cwr) check("sram_dq_out", 32'(dq_out), 32'(m_hi ? cd[31:16] : cd[15:0]));
      end
    end
  logic [17:0] s_addr0, s_addr1, s_addr2;
  logic [15:0] s_dq1, s_dq2;
  int lows, wl;
  task automatic preload(input logic [4:0] w, input logic [31:0] d);
    @(posedge clk); #1;
    ld_w = w; ld_d = d; ld_en = 1;
    @(posedge clk); #1;
    ld_en = 0;
  endtask
  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic done_f;
    @(posedge clk); #1;
    r_en = r; w_en = w; addr = a; wdata = d;
    lows = 0; wl = 0; done_f = 0;
    for (int i = 0; i < 40 && !done_f; i++) begin
      @(negedge clk);
      if (i == 0) s_addr0 = sram_addr;
      if (i == 1) begin s_addr1 = sram_addr; s_dq1 = dq_out; end
      if (i == P + 1) begin s_addr2 = sram_addr; s_dq2 = dq_out; end
      if (ready) done_f = 1;
      else begin
        lows++;
        if (!we_n && !sram_addr[0]) wl++;
      end
    end
    check("access_timeout", 32'(done_f), 1);
    @(posedge clk); #1;
    r_en = 0; w_en = 0;
  endtask
  logic [7:0] rv;
  logic [3:0] wv;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 chk_en = 1;
    check("rst_ready", 32'(ready), 1);
    check("rst_mem_result", mem_result, 0);
    check("rst_sram_addr", 32'(sram_addr), 0);
    check("rst_we_n", 32'(we_n), 1);
    check("rst_oe", 32'(dq_oe), 0);
    check("rst_dq_out", 32'(dq_out), 0);
    rst = 0;
    preload(5'd2, 32'h12345678);
    access(1, 0, 1032, 0);
    check("rd_lows", lows, 7);
    check("rd_result", mem_result, 32'h12345678);
    access(0, 1, 1032, 32'hDEADBEEF);
    check("wr_lows", lows, 7);
    check("wr_we_low_lo", wl, 2);
    check("wr_lo_addr", 32'(s_addr1), 4);
    check("wr_lo_dq", 32'(s_dq1), 32'hBEEF);
    check("wr_hi_addr", 32'(s_addr2), 5);
    check("wr_hi_dq", 32'(s_dq2), 32'hDEAD);
`ifdef SRAM_CTRL_READ_HIT_EN
    check("wr_through", mem_result, 32'hDEADBEEF);
`else
    check("wr_keeps_result", mem_result, 32'h12345678);
`endif
    access(1, 0, 1032, 0);
    check("rd2_result", mem_result, 32'hDEADBEEF);
`ifdef SRAM_CTRL_READ_HIT_EN
    check("rd2_hit_lows", lows, 0);
`else
    check("rd2_lows", lows, 7);
`endif
    access(1, 1, 1040, 32'h0BADF00D);
    check("rw_is_write", wl, 2);
    check("rw_keeps_result", mem_result, 32'hDEADBEEF);
    access(1, 0, 1040, 0);
    check("rd3_result", mem_result, 32'h0BADF00D);
    check("rd3_lows", lows, 7);
    access(1, 0, 1032, 0);
    check("rd4_result", mem_result, 32'hDEADBEEF);
    access(0, 1, 1032, 32'hCAFEF00D);
`ifdef SRAM_CTRL_READ_HIT_EN
    check("wr2_through", mem_result, 32'hCAFEF00D);
`else
    check("wr2_keeps_result", mem_result, 32'hDEADBEEF);
`endif
    access(1, 0, 1032, 0);
    check("rd5_result", mem_result, 32'hCAFEF00D);
`ifdef SRAM_CTRL_READ_HIT_EN
    check("rd5_hit_lows", lows, 0);
    check("rd5_hit_addr_held", 32'(s_addr0), 5);
`endif
    // reset in the second cycle of HI of a write
    @(posedge clk); #1;
    w_en = 1; addr = 1064; wdata = 32'h11112222;
    repeat (5) @(posedge clk);
    #1 check("mid_hi_we_n", 32'(we_n), 0);
    rst = 1; w_en = 0;
    @(negedge clk);
    check("rst_mid_we_n", 32'(we_n), 1);
    check("rst_mid_oe", 32'(dq_oe), 0);
    check("rst_mid_ready", 32'(ready), 1);
    check("rst_mid_result", mem_result, 0);
    @(posedge clk); #1;
    rst = 0;
    // P=1: back-to-back reads then a write
    @(posedge clk); #1;
    r1 = 1; a1 = 1024;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rv[c] = ready1;
    end
    @(posedge clk); #1;
    r1 = 0; w1 = 1; d1 = 32'h55667788;
    check("p1_ready_pulses", 32'(rv), 32'h88);
    check("p1_result", mem_result1, 32'h00A500A5);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      wv[c] = we_n1;
    end
    @(posedge clk); #1;
    w1 = 0;
    check("p1_we_n", 32'(wv), 32'h9);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
